// File: rtl/msg_field_extract_pipe_pkg.sv
// Shared definitions for the message field extractor.
// Holds the message width, the message type codes, the miss/disabled default
// value and the field geometry used when the table is loaded with its usual
// contents.
package msg_field_extract_pipe_pkg;

    localparam int unsigned MAX_MESSAGE_BITS = 512;

    // Message type codes as carried on in_type / cfg_type.
    typedef enum logic [1:0] {
        MsgNone = 2'd0,
        MsgA    = 2'd1,
        MsgD    = 2'd2,
        MsgK    = 2'd3
    } msg_type_e;

    localparam msg_type_e message_mux_a = MsgA;
    localparam msg_type_e message_mux_d = MsgD;
    localparam msg_type_e message_mux_k = MsgK;

    // Value presented when a type misses or extraction is disabled.
    localparam logic [31:0] defaut_infor = 32'h0000_0000;

    // Usual table-load geometry (bit width / LSB offset of each field).
    localparam int unsigned a_SP4_e_width = 32;
    localparam int unsigned a_SP4_e_off   = 64;
    localparam int unsigned d_SP4_e_width = 32;
    localparam int unsigned d_SP4_e_off   = 128;
    localparam int unsigned k_SP4_e_width = 32;
    localparam int unsigned k_SP4_e_off   = 256;

endpackage

// File: rtl/msg_field_extract_lane.sv
// One lane of the field extractor: two-stage elastic pipeline.
// S1 captures the message, the looked-up table entry and en; S2 holds the
// shifted field, the hit flag and the captured en. A saturating counter
// tracks results that leave S2 with en=1 and no hit.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            global extract enable (captured with the message)
//   entry_valid   table entry enable for this lane's current in_type
//   entry_off     table entry LSB offset for this lane's current in_type
//   in_valid/in_ready/in_msg      upstream handshake and message
//   out_valid/out_ready           downstream handshake
//   out_field/out_hit             extracted field and match flag
//   miss_cnt      saturating count of unrecognised-type results
module msg_field_extract_lane
    import msg_field_extract_pipe_pkg::*;
#(
    parameter int unsigned           MSG_BITS    = MAX_MESSAGE_BITS,
    parameter int unsigned           FIELD_BITS  = 32,
    parameter int unsigned           OFF_W       = 9,
    parameter logic [FIELD_BITS-1:0] DEFAULT_VAL = FIELD_BITS'(defaut_infor),
    parameter int unsigned           CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  entry_valid,
    input  logic [OFF_W-1:0]      entry_off,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MSG_BITS-1:0]   in_msg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FIELD_BITS-1:0] out_field,
    output logic                  out_hit,
    output logic [CNT_W-1:0]      miss_cnt
);

    logic                  s1_v_q;
    logic [MSG_BITS-1:0]   s1_msg_q;
    logic [OFF_W-1:0]      s1_off_q;
    logic                  s1_ent_v_q;
    logic                  s1_en_q;

    logic                  s2_v_q;
    logic [FIELD_BITS-1:0] s2_field_q;
    logic [FIELD_BITS-1:0] s2_field_d;
    logic                  s2_hit_q;
    logic                  s2_hit_d;
    logic                  s2_en_q;

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic s2_adv;
    logic s1_adv;
    logic accept;
    logic leave_miss;

    assign s2_adv   = ~s2_v_q | out_ready;
    assign s1_adv   = ~s1_v_q | s2_adv;
    assign in_ready = ~rst & s1_adv;
    assign accept   = in_valid & in_ready;

    // Right shift zero-fills, so bits past the top of the message read as 0.
    always_comb begin
        s2_hit_d   = s1_en_q & s1_ent_v_q;
        s2_field_d = DEFAULT_VAL;
        if (s2_hit_d) begin
            s2_field_d = FIELD_BITS'(s1_msg_q >> s1_off_q);
        end
    end

    assign leave_miss = s2_v_q & out_ready & s2_en_q & ~s2_hit_q;

    always_comb begin
        cnt_d = cnt_q;
        if (leave_miss && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Control and result state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_field_q <= DEFAULT_VAL;
            s2_hit_q   <= 1'b0;
            s2_en_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_q <= accept;
            end
            if (s2_adv) begin
                s2_v_q <= s1_v_q;
                if (s1_v_q) begin
                    s2_field_q <= s2_field_d;
                    s2_hit_q   <= s2_hit_d;
                    s2_en_q    <= s1_en_q;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    // S1 payload needs no reset: it is only consumed while s1_v_q is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_msg_q   <= in_msg;
            s1_off_q   <= entry_off;
            s1_ent_v_q <= entry_valid;
            s1_en_q    <= en;
        end
    end

    assign out_valid = s2_v_q;
    assign out_field = rst ? DEFAULT_VAL : s2_field_q;
    assign out_hit   = s2_hit_q & ~rst;
    assign miss_cnt  = cnt_q;

endmodule

// File: rtl/msg_field_extract_pipe.sv
// Multi-lane field extractor. Holds the runtime-loadable {valid, off} table
// indexed by message type and instantiates one pipelined lane per channel.
// Table reads are combinational from the registered table, so a message
// accepted on the same edge as a table write sees the old entry.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   en                               global extract enable
//   cfg_we/cfg_type/cfg_off/cfg_valid table write port
//   in_valid/in_ready/in_msg/in_type  per-lane input handshake and payload
//   out_valid/out_ready              per-lane output handshake
//   out_field/out_hit                per-lane extracted field and match flag
//   miss_cnt                         per-lane saturating miss counters
module msg_field_extract_pipe
    import msg_field_extract_pipe_pkg::*;
#(
    parameter int unsigned           NUM_CH      = 3,
    parameter int unsigned           MSG_BITS    = MAX_MESSAGE_BITS,
    parameter int unsigned           FIELD_BITS  = 32,
    parameter int unsigned           CTRL_W      = 2,
    parameter int unsigned           OFF_W       = 9,
    parameter logic [FIELD_BITS-1:0] DEFAULT_VAL = FIELD_BITS'(defaut_infor),
    parameter int unsigned           CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         cfg_we,
    input  logic [CTRL_W-1:0]            cfg_type,
    input  logic [OFF_W-1:0]             cfg_off,
    input  logic                         cfg_valid,
    input  logic [NUM_CH-1:0]            in_valid,
    output logic [NUM_CH-1:0]            in_ready,
    input  logic [NUM_CH*MSG_BITS-1:0]   in_msg,
    input  logic [NUM_CH*CTRL_W-1:0]     in_type,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*FIELD_BITS-1:0] out_field,
    output logic [NUM_CH-1:0]            out_hit,
    output logic [NUM_CH*CNT_W-1:0]      miss_cnt
);

    localparam int unsigned Entries = 2 ** CTRL_W;

    logic [Entries-1:0] tbl_valid_q;
    logic [OFF_W-1:0]   tbl_off_q [Entries];

    always_ff @(posedge clk) begin
        if (rst) begin
            tbl_valid_q <= '0;
            for (int i = 0; i < Entries; i++) begin
                tbl_off_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_valid_q[cfg_type] <= cfg_valid;
            tbl_off_q[cfg_type]   <= cfg_off;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        logic [CTRL_W-1:0] lane_type;
        assign lane_type = in_type[c*CTRL_W +: CTRL_W];

        msg_field_extract_lane #(
            .MSG_BITS    (MSG_BITS),
            .FIELD_BITS  (FIELD_BITS),
            .OFF_W       (OFF_W),
            .DEFAULT_VAL (DEFAULT_VAL),
            .CNT_W       (CNT_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .entry_valid (tbl_valid_q[lane_type]),
            .entry_off   (tbl_off_q[lane_type]),
            .in_valid    (in_valid[c]),
            .in_ready    (in_ready[c]),
            .in_msg      (in_msg[c*MSG_BITS +: MSG_BITS]),
            .out_valid   (out_valid[c]),
            .out_ready   (out_ready[c]),
            .out_field   (out_field[c*FIELD_BITS +: FIELD_BITS]),
            .out_hit     (out_hit[c]),
            .miss_cnt    (miss_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_msg_field_extract_pipe.sv
// Bench for msg_field_extract_pipe: a per-lane queue model of in-flight
// results checked every cycle, plus directed scenarios with literal results.
module tb_msg_field_extract_pipe;

    localparam int NCH = 3;
    localparam int MB  = 512;
    localparam int FB  = 32;
    localparam int CW  = 2;
    localparam int OW  = 9;
    localparam int NW  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_we;
    logic [CW-1:0]     cfg_type;
    logic [OW-1:0]     cfg_off;
    logic              cfg_valid;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*MB-1:0] in_msg;
    logic [NCH*CW-1:0] in_type;
    logic [NCH-1:0]    out_valid;
    logic [NCH-1:0]    out_ready;
    logic [NCH*FB-1:0] out_field;
    logic [NCH-1:0]    out_hit;
    logic [NCH*NW-1:0] miss_cnt;

    msg_field_extract_pipe #(
        .NUM_CH     (NCH),
        .MSG_BITS   (MB),
        .FIELD_BITS (FB),
        .CTRL_W     (CW),
        .OFF_W      (OW),
        .DEFAULT_VAL(32'h0),
        .CNT_W      (NW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_we    (cfg_we),
        .cfg_type  (cfg_type),
        .cfg_off   (cfg_off),
        .cfg_valid (cfg_valid),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_msg    (in_msg),
        .in_type   (in_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_field (out_field),
        .out_hit   (out_hit),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [31:0] f;
        logic        h;
        logic        e;
        int          cyc;
    } item_t;

    item_t       q[NCH][$];
    logic        tv[4];
    int          to[4];
    int          mcnt[NCH];
    int          cyc = 0;
    logic [31:0] got_f[NCH][$];
    logic        got_h[NCH][$];

    // Field = message bits [off +: 32], bits past the top of the message are 0.
    function automatic logic [31:0] fld(input logic [MB-1:0] m, input int off);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 32; i++) begin
            if (off + i < MB) f[i] = m[off+i];
        end
        return f;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            tv[i] = 1'b0;
            to[i] = 0;
        end
        for (int c = 0; c < NCH; c++) mcnt[c] = 0;
    end

    always @(negedge clk) begin : monitor
        logic  er;
        logic  ev;
        item_t it;
        int    t;
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("miss_cnt[%0d]", c), miss_cnt[c*NW +: NW], mcnt[c]);
            if (rst) begin
                chk($sformatf("rst_in_ready[%0d]", c), in_ready[c], 0);
                chk($sformatf("rst_out_field[%0d]", c), out_field[c*FB +: FB], 0);
                chk($sformatf("rst_out_hit[%0d]", c), out_hit[c], 0);
                q[c].delete();
                mcnt[c] = 0;
            end else begin
                er = (q[c].size() < 2) || out_ready[c];
                ev = (q[c].size() > 0) && (cyc - q[c][0].cyc >= 2);
                chk($sformatf("in_ready[%0d]", c), in_ready[c], er);
                chk($sformatf("out_valid[%0d]", c), out_valid[c], ev);
                if (out_valid[c] && q[c].size() > 0) begin
                    chk($sformatf("out_field[%0d]", c), out_field[c*FB +: FB], q[c][0].f);
                    chk($sformatf("out_hit[%0d]", c), out_hit[c], q[c][0].h);
                    if (out_ready[c]) begin
                        got_f[c].push_back(out_field[c*FB +: FB]);
                        got_h[c].push_back(out_hit[c]);
                        if (q[c][0].e && !q[c][0].h && mcnt[c] < 65535) mcnt[c]++;
                        void'(q[c].pop_front());
                    end
                end
                if (in_valid[c] && er) begin
                    t      = int'(in_type[c*CW +: CW]);
                    it.e   = en;
                    it.h   = en & tv[t];
                    it.f   = it.h ? fld(in_msg[c*MB +: MB], to[t]) : 32'h0;
                    it.cyc = cyc;
                    q[c].push_back(it);
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                tv[i] = 1'b0;
                to[i] = 0;
            end
        end else if (cfg_we) begin
            tv[cfg_type] = cfg_valid;
            to[cfg_type] = int'(cfg_off);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (5) step();
    endtask

    task automatic cfg(input logic [1:0] t, input int off, input logic v);
        cfg_we = 1'b1; cfg_type = t; cfg_off = OW'(off); cfg_valid = v;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic send(input int c, input logic [MB-1:0] m, input logic [1:0] t);
        bit done;
        done = 0;
        in_msg[c*MB +: MB] = m;
        in_type[c*CW +: CW] = t;
        in_valid[c] = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready[c];
            step();
        end
        in_valid[c] = 1'b0;
        if (!done) chk($sformatf("accept_timeout[%0d]", c), 0, 1);
    endtask

    function automatic logic [MB-1:0] mk(input int c, input int s);
        logic [MB-1:0] m;
        m = {16{32'h5A5A_5A5A}};
        m[95:64] = 32'hC0DE_0000 | (c << 8) | s;
        return m;
    endfunction

    initial begin : main
        logic [MB-1:0] m;
        int            seq[NCH];
        int            acc_st[NCH];
        logic          acc[NCH];

        rst = 1'b1; en = 1'b1; cfg_we = 1'b0; cfg_type = '0; cfg_off = '0; cfg_valid = 1'b0;
        in_valid = '0; in_msg = '0; in_type = '0; out_ready = '1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // Field at offset 64 with literal latency check.
        cfg(2'd1, 64, 1'b1);
        m = {16{32'h1234_5678}};
        m[95:64] = 32'hDEAD_BEEF;
        in_msg[MB-1:0] = m; in_type[1:0] = 2'd1; in_valid[0] = 1'b1;
        @(negedge clk);
        chk("lat_accept", in_ready[0], 1);
        step();
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid[0], 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid[0], 1);
        chk("lat_field", out_field[31:0], 32'hDEAD_BEEF);
        chk("lat_hit", out_hit[0], 1);
        drain();

        // Unprogrammed type 2 misses; then with en=0 nothing is counted.
        got_f[0].delete(); got_h[0].delete();
        for (int i = 0; i < 3; i++) send(0, mk(0, i), 2'd2);
        drain();
        chk("miss3_cnt", miss_cnt[15:0], 3);
        chk("miss3_n", got_f[0].size(), 3);
        for (int i = 0; i < got_f[0].size(); i++) begin
            chk("miss_field", got_f[0][i], 0);
            chk("miss_hit", got_h[0][i], 0);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) send(0, mk(0, i), 2'd2);
        send(0, mk(0, 7), 2'd1);
        drain();
        en = 1'b1;
        chk("en0_cnt", miss_cnt[15:0], 3);
        chk("en0_hit", got_h[0][got_h[0].size()-1], 0);

        // Offset near the top of the message.
        cfg(2'd3, 500, 1'b1);
        m = '1;
        m[511:500] = 12'hABC;
        send(0, m, 2'd3);
        drain();
        chk("off500_field", got_f[0][got_f[0].size()-1], 32'h0000_0ABC);

        // Lane 1 stalled for 5 cycles while all lanes stream.
        for (int c = 0; c < NCH; c++) begin
            seq[c] = 0; acc_st[c] = 0; got_f[c].delete(); got_h[c].delete();
            in_type[c*CW +: CW] = 2'd1;
        end
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < NCH; c++) begin
                in_valid[c] = (seq[c] < 8);
                in_msg[c*MB +: MB] = mk(c, seq[c]);
            end
            out_ready[1] = (k >= 5);
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                acc[c] = in_valid[c] & in_ready[c];
                if (k < 5 && acc[c]) acc_st[c]++;
            end
            step();
            for (int c = 0; c < NCH; c++) if (acc[c]) seq[c]++;
        end
        in_valid = '0;
        drain();
        chk("stall_lane1_buffered", acc_st[1], 2);
        chk("stall_lane0_rate", acc_st[0], 5);
        chk("stall_lane2_rate", acc_st[2], 5);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("stream_count[%0d]", c), got_f[c].size(), 8);
            for (int s = 0; s < got_f[c].size(); s++)
                chk($sformatf("stream_order[%0d]", c), got_f[c][s], 32'hC0DE_0000 | (c << 8) | s);
        end

        // Table write on the same edge as a type-1 acceptance.
        m = '0;
        m[95:64] = 32'h1111_1111;
        m[31:0]  = 32'h2222_2222;
        cfg_we = 1'b1; cfg_type = 2'd1; cfg_off = 9'd0; cfg_valid = 1'b1;
        in_msg[MB-1:0] = m; in_type[1:0] = 2'd1; in_valid[0] = 1'b1;
        @(negedge clk);
        chk("race_accept", in_ready[0], 1);
        step();
        cfg_we = 1'b0;
        m[31:0] = 32'h3333_3333;
        in_msg[MB-1:0] = m;
        @(negedge clk);
        chk("race_accept2", in_ready[0], 1);
        step();
        in_valid[0] = 1'b0;
        drain();
        chk("race_old_off", got_f[0][got_f[0].size()-2], 32'h1111_1111);
        chk("race_new_off", got_f[0][got_f[0].size()-1], 32'h3333_3333);

        // Reset with lane 2 holding two results.
        out_ready[2] = 1'b0;
        send(2, mk(2, 0), 2'd1);
        send(2, mk(2, 1), 2'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid2", out_valid[2], 0);
        chk("post_rst_cnt0", miss_cnt[15:0], 0);
        out_ready[2] = 1'b1;
        step();
        got_f[0].delete(); got_h[0].delete();
        send(0, mk(0, 9), 2'd1);
        drain();
        chk("post_rst_n", got_f[0].size(), 1);
        if (got_f[0].size() > 0) begin
            chk("post_rst_field", got_f[0][0], 0);
            chk("post_rst_hit", got_h[0][0], 0);
        end
        chk("post_rst_cnt_after", miss_cnt[15:0], 1);
        for (int c = 0; c < NCH; c++) chk($sformatf("drained[%0d]", c), q[c].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
